trap_ctrl: RTL and testbench
============================

Name: trap_ctrl

Overview:
Machine-mode trap sequencer that sits between the pipeline commit point and the CSR block. It arbitrates synchronous exceptions, external/timer/software interrupts and MRET, then drains the pipeline. It issues a single-cycle CSR update carrying the mcause/mepc/mtval/mstatus values, and hands the redirect PC to fetch through a valid/ready handshake.

Parameters:
SYNC_STAGES, 2, synchronizer depth for the asynchronous ext_irq input (legal values 2..3)
MPP_MODE, 2'b11, privilege value written to mstatus.MPP on trap entry (M-only core)

Ports:
clk  in  1  core clock
rst  in  1  asynchronous reset, active-low
exc_valid  in  1  synchronous exception at commit
exc_code  in  31  exception code
exc_pc  in  32  PC of the faulting instruction
exc_tval  in  32  trap value
mret_valid  in  1  MRET at commit
commit_valid  in  1  a valid instruction is at commit
commit_pc  in  32  PC of that instruction
ext_irq  in  1  external interrupt, level, asynchronous
timer_irq  in  1  timer interrupt, level, synchronous
sw_irq  in  1  software interrupt, level, synchronous
i_mie  in  3  enable bits {MEIE, MTIE, MSIE}
i_mstatus_mie  in  1  current mstatus.MIE
i_mstatus_mpie  in  1  current mstatus.MPIE
i_mtvec_base  in  30  mtvec base
i_mtvec_mode  in  2  mtvec mode
i_mepc_value  in  32  current mepc
pipe_drained  in  1  pipeline is empty after flush
o_flush  out  1  kill all in-flight instructions
o_busy  out  1  FSM not in IDLE
o_csr_update  out  1  one-cycle write strobe to the CSR block
o_mcause_interrupt  out  1  value to write to mcause[31]
o_mcause_exception_code  out  31  value to write to mcause[30:0]
o_mepc_value  out  32  value to write to mepc
o_mtval_value  out  32  value to write to mtval
o_mstatus_mie  out  1  value to write to mstatus.MIE
o_mstatus_mpie  out  1  value to write to mstatus.MPIE
o_mstatus_mpp  out  2  value to write to mstatus.MPP
o_redirect_valid  out  1  redirect PC is valid
o_redirect_pc  out  32  new fetch PC
redirect_ready  in  1  fetch accepts the redirect

Behaviour:
- Reset (rst low, asynchronous): FSM to IDLE. All outputs 0 except o_mstatus_mpp=MPP_MODE. Shadow registers and synchronizer flops cleared.
- ext_irq passes through a SYNC_STAGES flop chain. timer_irq and sw_irq are used directly.
- Interrupt pending: irq_take = commit_valid & i_mstatus_mie & |(irq_vec & i_mie).
- Priority in IDLE: exc_valid > irq_take > mret_valid. Among interrupts: MEI (code 11) > MSI (3) > MTI (7).
- States: IDLE, FLUSH, UPDATE, REDIRECT.
- IDLE to FLUSH on any accepted event. In the same edge, latch into the shadow registers:
  - exception: cause={0,exc_code}, epc=exc_pc, tval=exc_tval.
  - interrupt: cause={1,code}, epc=commit_pc, tval=0.
  - mret: shadow cause/tval unchanged, epc=i_mepc_value.
- FLUSH: o_flush=1. Stay until pipe_drained=1, then go to UPDATE. Minimum one FLUSH cycle even if already drained.
- UPDATE: exactly one cycle, o_csr_update=1. Output values:
  - trap entry: mie=0, mpie=i_mstatus_mie, mpp=MPP_MODE, mepc=shadow epc, mcause=shadow cause, mtval=shadow tval.
  - mret: mie=i_mstatus_mpie, mpie=1, mpp=MPP_MODE, mepc=i_mepc_value, mcause/mtval=shadow (re-present the last trap values).
  - Compute and register the redirect PC:
    - mret: epc.
    - interrupt with i_mtvec_mode==2'b01: {i_mtvec_base,2'b00} + 4*code.
    - otherwise: {i_mtvec_base,2'b00}.
  - Arithmetic is 32-bit and wraps modulo 2^32.
- REDIRECT: o_redirect_valid=1 with o_redirect_pc stable until redirect_ready. Return to IDLE on the handshake cycle.
- o_busy=1 in every state other than IDLE. Events arriving while busy are ignored; level interrupts are re-evaluated in IDLE.
- exc_valid and mret_valid in the same cycle: take the exception; drop the mret.
- Deassertion of ext_irq during FLUSH does not abort the trap. The cause is already latched.
- Reset asserted in any state returns to IDLE immediately with no partial CSR update.

Optional Feature:
TRAP_CTRL_STATS_EN:
- Defined: adds output o_trap_count (32-bit).
  - Increments on each UPDATE cycle for a trap entry; mret does not count.
  - Wraps from 0xFFFFFFFF to 0.
  - Resets to 0.
- Undefined: the port and the counter are absent.

Test Plan:
- exc_valid=1, exc_code=2, exc_pc=0x100, exc_tval=0xDEAD, mtvec_base=0x10, pipe_drained on 2nd FLUSH cycle -> o_csr_update one cycle with mcause=0x00000002, mepc=0x100, mtval=0xDEAD, mie=0; then redirect_pc=0x40.
- mtvec_mode=1, mstatus_mie=1, i_mie=3'b111, timer_irq=1, commit_pc=0x200 -> mcause=0x80000007, mepc=0x200, redirect_pc=0x40+28=0x5C.
- ext_irq, sw_irq and timer_irq all high, all enabled -> mcause code 11. ext_irq is first visible SYNC_STAGES cycles after assertion.
- mret_valid with mepc=0x300, mpie=1 -> o_mstatus_mie=1, mpie=1, redirect_pc=0x300.
- exc_valid and mret_valid together; redirect_ready held low for 5 cycles -> exception taken; o_redirect_valid and o_redirect_pc stable for 5 cycles; o_busy high throughout.
- rst low during FLUSH -> all outputs cleared asynchronously, no o_csr_update pulse. With TRAP_CTRL_STATS_EN, o_trap_count=0 afterwards.

Source files
------------

// File: rtl/trap_ctrl.sv
// Machine-mode trap sequencer: arbitrates exceptions, interrupts and MRET, drains the pipeline,
// issues a one-cycle CSR update and hands the redirect PC to fetch. Optional: TRAP_CTRL_STATS_EN.
module trap_ctrl #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic [1:0]  MPP_MODE    = 2'b11
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        exc_valid,
  input  logic [30:0] exc_code,
  input  logic [31:0] exc_pc,
  input  logic [31:0] exc_tval,
  input  logic        mret_valid,
  input  logic        commit_valid,
  input  logic [31:0] commit_pc,
  input  logic        ext_irq,
  input  logic        timer_irq,
  input  logic        sw_irq,
  input  logic [2:0]  i_mie,
  input  logic        i_mstatus_mie,
  input  logic        i_mstatus_mpie,
  input  logic [29:0] i_mtvec_base,
  input  logic [1:0]  i_mtvec_mode,
  input  logic [31:0] i_mepc_value,
  input  logic        pipe_drained,
  output logic        o_flush,
  output logic        o_busy,
  output logic        o_csr_update,
  output logic        o_mcause_interrupt,
  output logic [30:0] o_mcause_exception_code,
  output logic [31:0] o_mepc_value,
  output logic [31:0] o_mtval_value,
  output logic        o_mstatus_mie,
  output logic        o_mstatus_mpie,
  output logic [1:0]  o_mstatus_mpp,
  output logic        o_redirect_valid,
  output logic [31:0] o_redirect_pc,
  input  logic        redirect_ready
`ifdef TRAP_CTRL_STATS_EN
  ,
  output logic [31:0] o_trap_count
`endif
);

  typedef enum logic [1:0] {StIdle, StFlush, StUpdate, StRedirect} state_e;

  state_e state_q, state_d;

  logic [SYNC_STAGES-1:0] ext_sync_q;
  logic [2:0]             irq_en;
  logic                   irq_take;
  logic [30:0]            irq_code;
  logic                   take_exc, take_irq, take_mret;

  logic        cause_irq_q;
  logic [30:0] cause_code_q;
  logic [31:0] epc_q, tval_q, redirect_pc_q, redirect_pc_d, mtvec_addr;
  logic        mret_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) ext_sync_q <= '0;
    else      ext_sync_q <= {ext_sync_q[SYNC_STAGES-2:0], ext_irq};
  end

  // Bit order matches i_mie: {MEIE, MTIE, MSIE}
  assign irq_en   = {ext_sync_q[SYNC_STAGES-1], timer_irq, sw_irq} & i_mie;
  assign irq_take = commit_valid & i_mstatus_mie & (|irq_en);

  always_comb begin
    irq_code = 31'd7;
    if (irq_en[2])      irq_code = 31'd11;
    else if (irq_en[0]) irq_code = 31'd3;
  end

  always_comb begin
    state_d   = state_q;
    take_exc  = 1'b0;
    take_irq  = 1'b0;
    take_mret = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (exc_valid) begin
          take_exc = 1'b1;
          state_d  = StFlush;
        end else if (irq_take) begin
          take_irq = 1'b1;
          state_d  = StFlush;
        end else if (mret_valid) begin
          take_mret = 1'b1;
          state_d   = StFlush;
        end
      end
      StFlush:    if (pipe_drained) state_d = StUpdate;
      StUpdate:   state_d = StRedirect;
      StRedirect: if (redirect_ready) state_d = StIdle;
      default:    state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= StIdle;
    else      state_q <= state_d;
  end

  // MRET keeps the last trap's cause/tval so UPDATE can re-present them
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cause_irq_q  <= 1'b0;
      cause_code_q <= '0;
      epc_q        <= '0;
      tval_q       <= '0;
      mret_q       <= 1'b0;
    end else if (take_exc) begin
      cause_irq_q  <= 1'b0;
      cause_code_q <= exc_code;
      epc_q        <= exc_pc;
      tval_q       <= exc_tval;
      mret_q       <= 1'b0;
    end else if (take_irq) begin
      cause_irq_q  <= 1'b1;
      cause_code_q <= irq_code;
      epc_q        <= commit_pc;
      tval_q       <= '0;
      mret_q       <= 1'b0;
    end else if (take_mret) begin
      epc_q  <= i_mepc_value;
      mret_q <= 1'b1;
    end
  end

  assign mtvec_addr = {i_mtvec_base, 2'b00};

  always_comb begin
    redirect_pc_d = mtvec_addr;
    if (mret_q) begin
      redirect_pc_d = epc_q;
    end else if (cause_irq_q && (i_mtvec_mode == 2'b01)) begin
      redirect_pc_d = mtvec_addr + {cause_code_q[29:0], 2'b00};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                    redirect_pc_q <= '0;
    else if (state_q == StUpdate) redirect_pc_q <= redirect_pc_d;
  end

  always_comb begin
    o_busy                  = (state_q != StIdle);
    o_flush                 = (state_q == StFlush);
    o_redirect_valid        = (state_q == StRedirect);
    o_redirect_pc           = redirect_pc_q;
    o_csr_update            = 1'b0;
    o_mcause_interrupt      = 1'b0;
    o_mcause_exception_code = '0;
    o_mepc_value            = '0;
    o_mtval_value           = '0;
    o_mstatus_mie           = 1'b0;
    o_mstatus_mpie          = 1'b0;
    o_mstatus_mpp           = MPP_MODE;
    if (state_q == StUpdate) begin
      o_csr_update            = 1'b1;
      o_mcause_interrupt      = cause_irq_q;
      o_mcause_exception_code = cause_code_q;
      o_mtval_value           = tval_q;
      if (mret_q) begin
        o_mstatus_mie  = i_mstatus_mpie;
        o_mstatus_mpie = 1'b1;
        o_mepc_value   = i_mepc_value;
      end else begin
        o_mstatus_mie  = 1'b0;
        o_mstatus_mpie = i_mstatus_mie;
        o_mepc_value   = epc_q;
      end
    end
  end

`ifdef TRAP_CTRL_STATS_EN
  logic [31:0] trap_cnt_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                                trap_cnt_q <= '0;
    else if (state_q == StUpdate && !mret_q) trap_cnt_q <= trap_cnt_q + 32'd1;
  end

  assign o_trap_count = trap_cnt_q;
`endif

endmodule

// File: tb/tb_trap_ctrl.sv
// Directed self-checking bench for trap_ctrl.
module tb_trap_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        exc_valid, mret_valid, commit_valid;
  logic [30:0] exc_code;
  logic [31:0] exc_pc, exc_tval, commit_pc;
  logic        ext_irq, timer_irq, sw_irq;
  logic [2:0]  i_mie;
  logic        i_mstatus_mie, i_mstatus_mpie;
  logic [29:0] i_mtvec_base;
  logic [1:0]  i_mtvec_mode;
  logic [31:0] i_mepc_value;
  logic        pipe_drained, redirect_ready;
  logic        o_flush, o_busy, o_csr_update, o_mcause_interrupt;
  logic [30:0] o_mcause_exception_code;
  logic [31:0] o_mepc_value, o_mtval_value, o_redirect_pc;
  logic        o_mstatus_mie, o_mstatus_mpie, o_redirect_valid;
  logic [1:0]  o_mstatus_mpp;
`ifdef TRAP_CTRL_STATS_EN
  logic [31:0] o_trap_count;
`endif

  int checks = 0;
  int errors = 0;

  trap_ctrl #(.SYNC_STAGES(2), .MPP_MODE(2'b11)) dut (
    .clk(clk), .rst(rst),
    .exc_valid(exc_valid), .exc_code(exc_code), .exc_pc(exc_pc), .exc_tval(exc_tval),
    .mret_valid(mret_valid), .commit_valid(commit_valid), .commit_pc(commit_pc),
    .ext_irq(ext_irq), .timer_irq(timer_irq), .sw_irq(sw_irq), .i_mie(i_mie),
    .i_mstatus_mie(i_mstatus_mie), .i_mstatus_mpie(i_mstatus_mpie),
    .i_mtvec_base(i_mtvec_base), .i_mtvec_mode(i_mtvec_mode), .i_mepc_value(i_mepc_value),
    .pipe_drained(pipe_drained), .o_flush(o_flush), .o_busy(o_busy),
    .o_csr_update(o_csr_update), .o_mcause_interrupt(o_mcause_interrupt),
    .o_mcause_exception_code(o_mcause_exception_code), .o_mepc_value(o_mepc_value),
    .o_mtval_value(o_mtval_value), .o_mstatus_mie(o_mstatus_mie),
    .o_mstatus_mpie(o_mstatus_mpie), .o_mstatus_mpp(o_mstatus_mpp),
    .o_redirect_valid(o_redirect_valid), .o_redirect_pc(o_redirect_pc),
    .redirect_ready(redirect_ready)
`ifdef TRAP_CTRL_STATS_EN
    , .o_trap_count(o_trap_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b0;
    exc_valid = 0; mret_valid = 0; commit_valid = 0;
    exc_code = '0; exc_pc = '0; exc_tval = '0; commit_pc = '0;
    ext_irq = 0; timer_irq = 0; sw_irq = 0; i_mie = '0;
    i_mstatus_mie = 0; i_mstatus_mpie = 0; i_mtvec_base = 30'h10; i_mtvec_mode = 2'b00;
    i_mepc_value = '0; pipe_drained = 0; redirect_ready = 0;
    #2;
    checks++;
    if ({o_flush, o_busy, o_csr_update, o_redirect_valid} !== 4'b0000) begin
      errors++; $display("FAIL reset_ctrl: got %b want 0000",
                         {o_flush, o_busy, o_csr_update, o_redirect_valid});
    end
    checks++;
    if (o_mstatus_mpp !== 2'b11) begin
      errors++; $display("FAIL reset_mpp: got %b want 11", o_mstatus_mpp);
    end
    checks++;
    if (o_redirect_pc !== 32'h0 || o_mepc_value !== 32'h0) begin
      errors++; $display("FAIL reset_pc: got redirect %h mepc %h want 0", o_redirect_pc,
                         o_mepc_value);
    end
    tick; tick;
    rst = 1'b1;
    tick;
  endtask

  task automatic test_exception;
    exc_valid = 1; exc_code = 31'd2; exc_pc = 32'h100; exc_tval = 32'hDEAD;
    pipe_drained = 0;
    tick;
    exc_valid = 0;
    checks++;
    if (o_flush !== 1'b1 || o_busy !== 1'b1 || o_csr_update !== 1'b0) begin
      errors++; $display("FAIL exc_flush1: got flush %b busy %b upd %b want 1 1 0",
                         o_flush, o_busy, o_csr_update);
    end
    tick;
    checks++;
    if (o_flush !== 1'b1 || o_csr_update !== 1'b0) begin
      errors++; $display("FAIL exc_flush2: got flush %b upd %b want 1 0", o_flush, o_csr_update);
    end
    pipe_drained = 1;
    tick;
    checks++;
    if (o_csr_update !== 1'b1 || o_mcause_interrupt !== 1'b0 ||
        o_mcause_exception_code !== 31'd2 || o_mepc_value !== 32'h100 ||
        o_mtval_value !== 32'hDEAD || o_mstatus_mie !== 1'b0 || o_flush !== 1'b0) begin
      errors++; $display("FAIL exc_update: got upd %b int %b code %0d mepc %h mtval %h mie %b",
                         o_csr_update, o_mcause_interrupt, o_mcause_exception_code,
                         o_mepc_value, o_mtval_value, o_mstatus_mie);
    end
    tick;
    checks++;
    if (o_csr_update !== 1'b0 || o_redirect_valid !== 1'b1 || o_redirect_pc !== 32'h40) begin
      errors++; $display("FAIL exc_redirect: got upd %b valid %b pc %h want 0 1 00000040",
                         o_csr_update, o_redirect_valid, o_redirect_pc);
    end
    redirect_ready = 1;
    tick;
    redirect_ready = 0;
    checks++;
    if (o_busy !== 1'b0 || o_redirect_valid !== 1'b0) begin
      errors++; $display("FAIL exc_idle: got busy %b valid %b want 0 0", o_busy,
                         o_redirect_valid);
    end
  endtask

  task automatic test_timer_vectored;
    i_mtvec_mode = 2'b01; i_mstatus_mie = 1; i_mie = 3'b111; timer_irq = 1;
    commit_valid = 1; commit_pc = 32'h200;
    tick;
    timer_irq = 0; commit_valid = 0;
    tick;
    checks++;
    if (o_csr_update !== 1'b1 || o_mcause_interrupt !== 1'b1 ||
        o_mcause_exception_code !== 31'd7 || o_mepc_value !== 32'h200 ||
        o_mtval_value !== 32'h0 || o_mstatus_mie !== 1'b0 || o_mstatus_mpie !== 1'b1) begin
      errors++; $display("FAIL tmr_update: got upd %b int %b code %0d mepc %h mtval %h mpie %b",
                         o_csr_update, o_mcause_interrupt, o_mcause_exception_code,
                         o_mepc_value, o_mtval_value, o_mstatus_mpie);
    end
    tick;
    checks++;
    if (o_redirect_valid !== 1'b1 || o_redirect_pc !== 32'h5C) begin
      errors++; $display("FAIL tmr_redirect: got valid %b pc %h want 1 0000005c",
                         o_redirect_valid, o_redirect_pc);
    end
    redirect_ready = 1;
    tick;
    redirect_ready = 0;
  endtask

  task automatic test_irq_priority;
    // Only MEIE enabled: the trap waits for the synchronizer
    i_mtvec_mode = 2'b00; i_mie = 3'b100; ext_irq = 1; timer_irq = 1; sw_irq = 1;
    commit_valid = 1; commit_pc = 32'h500;
    tick;
    checks++;
    if (o_busy !== 1'b0) begin
      errors++; $display("FAIL ext_sync1: got busy %b want 0", o_busy);
    end
    tick;
    checks++;
    if (o_busy !== 1'b0) begin
      errors++; $display("FAIL ext_sync2: got busy %b want 0", o_busy);
    end
    tick;
    commit_valid = 0;
    checks++;
    if (o_busy !== 1'b1) begin
      errors++; $display("FAIL ext_taken: got busy %b want 1", o_busy);
    end
    tick;
    checks++;
    if (o_mcause_interrupt !== 1'b1 || o_mcause_exception_code !== 31'd11 ||
        o_mepc_value !== 32'h500) begin
      errors++; $display("FAIL ext_update: got int %b code %0d mepc %h want 1 11 00000500",
                         o_mcause_interrupt, o_mcause_exception_code, o_mepc_value);
    end
    tick;
    redirect_ready = 1;
    tick;
    redirect_ready = 0;
    // All three enabled and pending: MEI wins
    i_mie = 3'b111; commit_valid = 1; commit_pc = 32'h600;
    tick;
    commit_valid = 0;
    tick;
    checks++;
    if (o_mcause_interrupt !== 1'b1 || o_mcause_exception_code !== 31'd11 ||
        o_mepc_value !== 32'h600) begin
      errors++; $display("FAIL prio_update: got int %b code %0d mepc %h want 1 11 00000600",
                         o_mcause_interrupt, o_mcause_exception_code, o_mepc_value);
    end
    tick;
    checks++;
    if (o_redirect_pc !== 32'h40) begin
      errors++; $display("FAIL prio_redirect: got pc %h want 00000040", o_redirect_pc);
    end
    redirect_ready = 1;
    tick;
    redirect_ready = 0;
    ext_irq = 0; timer_irq = 0; sw_irq = 0; i_mstatus_mie = 0;
  endtask

  task automatic test_mret;
    i_mepc_value = 32'h300; i_mstatus_mpie = 1; mret_valid = 1;
    tick;
    mret_valid = 0;
    tick;
    checks++;
    if (o_csr_update !== 1'b1 || o_mstatus_mie !== 1'b1 || o_mstatus_mpie !== 1'b1 ||
        o_mepc_value !== 32'h300 || o_mstatus_mpp !== 2'b11) begin
      errors++; $display("FAIL mret_update: got upd %b mie %b mpie %b mepc %h mpp %b",
                         o_csr_update, o_mstatus_mie, o_mstatus_mpie, o_mepc_value,
                         o_mstatus_mpp);
    end
    checks++;
    if (o_mcause_interrupt !== 1'b1 || o_mcause_exception_code !== 31'd11 ||
        o_mtval_value !== 32'h0) begin
      errors++; $display("FAIL mret_cause: got int %b code %0d mtval %h want 1 11 0",
                         o_mcause_interrupt, o_mcause_exception_code, o_mtval_value);
    end
    tick;
    checks++;
    if (o_redirect_valid !== 1'b1 || o_redirect_pc !== 32'h300) begin
      errors++; $display("FAIL mret_redirect: got valid %b pc %h want 1 00000300",
                         o_redirect_valid, o_redirect_pc);
    end
    redirect_ready = 1;
    tick;
    redirect_ready = 0;
    i_mstatus_mpie = 0;
  endtask

  task automatic test_back_to_back;
    exc_valid = 1; mret_valid = 1; exc_code = 31'd5; exc_pc = 32'h400; exc_tval = 32'h1234;
    i_mepc_value = 32'h900; i_mstatus_mie = 1;
    tick;
    exc_valid = 0; mret_valid = 0;
    tick;
    checks++;
    if (o_mcause_interrupt !== 1'b0 || o_mcause_exception_code !== 31'd5 ||
        o_mepc_value !== 32'h400 || o_mtval_value !== 32'h1234 || o_mstatus_mie !== 1'b0) begin
      errors++; $display("FAIL b2b_update: got int %b code %0d mepc %h mtval %h mie %b",
                         o_mcause_interrupt, o_mcause_exception_code, o_mepc_value,
                         o_mtval_value, o_mstatus_mie);
    end
    for (int i = 0; i < 5; i++) begin
      tick;
      checks++;
      if (o_redirect_valid !== 1'b1 || o_redirect_pc !== 32'h40 || o_busy !== 1'b1) begin
        errors++; $display("FAIL b2b_hold%0d: got valid %b pc %h busy %b want 1 00000040 1",
                           i, o_redirect_valid, o_redirect_pc, o_busy);
      end
    end
    redirect_ready = 1;
    tick;
    redirect_ready = 0;
    checks++;
    if (o_busy !== 1'b0 || o_redirect_valid !== 1'b0) begin
      errors++; $display("FAIL b2b_idle: got busy %b valid %b want 0 0", o_busy,
                         o_redirect_valid);
    end
    i_mstatus_mie = 0;
`ifdef TRAP_CTRL_STATS_EN
    checks++;
    if (o_trap_count !== 32'd5) begin
      errors++; $display("FAIL trap_count: got %0d want 5", o_trap_count);
    end
`endif
  endtask

  task automatic test_reset_in_flush;
    exc_valid = 1; exc_code = 31'd1; pipe_drained = 1;
    tick;
    exc_valid = 0;
    #2;
    rst = 1'b0;
    #1;
    checks++;
    if ({o_flush, o_busy, o_csr_update, o_redirect_valid} !== 4'b0000 ||
        o_mstatus_mpp !== 2'b11 || o_redirect_pc !== 32'h0) begin
      errors++; $display("FAIL rst_async: got ctrl %b mpp %b pc %h want 0000 11 0",
                         {o_flush, o_busy, o_csr_update, o_redirect_valid}, o_mstatus_mpp,
                         o_redirect_pc);
    end
    tick;
    checks++;
    if (o_csr_update !== 1'b0 || o_busy !== 1'b0) begin
      errors++; $display("FAIL rst_hold: got upd %b busy %b want 0 0", o_csr_update, o_busy);
    end
    rst = 1'b1;
    tick;
    checks++;
    if (o_csr_update !== 1'b0 || o_busy !== 1'b0) begin
      errors++; $display("FAIL rst_release: got upd %b busy %b want 0 0", o_csr_update, o_busy);
    end
`ifdef TRAP_CTRL_STATS_EN
    checks++;
    if (o_trap_count !== 32'd0) begin
      errors++; $display("FAIL rst_count: got %0d want 0", o_trap_count);
    end
`endif
  endtask

  initial begin
    test_reset;
    test_exception;
    test_timer_vectored;
    test_irq_priority;
    test_mret;
    test_back_to_back;
    test_reset_in_flush;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
